sparse_index_queue: RTL and testbench
=====================================

Name: sparse_index_queue

Overview:
Parametrised, single-clock successor to the input-pixel index queue. Scans a frame of INPUT_NODES multi-bit pixels, one per accepted beat, and enqueues the index of every pixel at or above a runtime threshold. Storage is a ping-pong pair of banks: one bank fills while the other drains to the neural-network controller through a valid/ready handshake. Sits between the image input stream and the first-layer accumulate controller.

Parameters:
INPUT_NODES, 784, pixels per frame (>=2)
QUEUE_DEPTH, 784, entries per bank (>=1)
PIXEL_WIDTH, 1, bits per pixel
IDX_W, $clog2(INPUT_NODES), derived index width
CNT_W, $clog2(QUEUE_DEPTH+1), derived count width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
pixelValid  in  1  pixelValue is valid this cycle
pixelValue  in  PIXEL_WIDTH  current pixel
pixelThreshold  in  PIXEL_WIDTH  enqueue if pixelValue >= pixelThreshold (unsigned)
swapBuffer  in  1  single-cycle request to hand the filled bank to the read side
finished  out  1  write bank has consumed INPUT_NODES pixels
overflow  out  1  sticky: a qualifying pixel was dropped because the bank was full
writeCount  out  CNT_W  entries in the write bank
swapRejected  out  1  one-cycle pulse: swapBuffer arrived while finished=0
indexOut  out  IDX_W  head-of-queue index, read bank
indexValid  out  1  indexOut holds an unread entry
indexReady  in  1  consumer accepts indexOut
queueEmpty  out  1  equals ~indexValid
readRemaining  out  CNT_W  unread entries in the read bank

Behaviour:
- Reset (sync, highest priority): pixel counter=0, wrPtr=0, finished=0, overflow=0, swapRejected=0, bank select=0, readPtr=readEnd=0, so indexValid=0, queueEmpty=1, writeCount=0, readRemaining=0. Bank contents are not cleared.
- Scan: on pixelValid & ~finished:
  - Qualifying pixel with writeCount<QUEUE_DEPTH: store pixel counter at wrPtr, wrPtr+1.
  - Qualifying pixel with bank full: entry dropped, overflow<=1.
  - Pixel counter increments on every accepted beat, whatever the pixel value.
  - The beat where counter==INPUT_NODES-1 sets finished=1 on the next edge. The counter does not wrap.
  - pixelValid while finished=1 is ignored.
- Swap: swapBuffer & finished:
  - Next cycle the filled bank becomes the read bank (bank select toggles), readEnd<=wrPtr, readPtr<=0.
  - Write side clears: counter=0, wrPtr=0, finished=0, overflow=0.
  - Unread entries in the old read bank are discarded.
  - A pixelValid on the swap cycle is ignored (finished=1).
- swapBuffer & ~finished: no state change; swapRejected=1 for exactly the next cycle.
- Read handshake:
  - indexValid = (readPtr != readEnd). indexOut is a combinational read of bank[readSel][readPtr] and is held stable while indexValid & ~indexReady.
  - A transfer (indexValid & indexReady) increments readPtr at the edge. Back-to-back transfers run one per cycle.
  - indexReady with indexValid=0 has no effect.
- Transfer and swap in the same cycle: the transfer counts as delivered; swap's readPtr<=0 wins.
- Latency: a qualifying pixel is readable no earlier than 1 cycle after the swap that follows frame completion.
- readRemaining = readEnd - readPtr. A zero-entry frame swaps cleanly and yields queueEmpty=1.

Optional Feature:
SIQ_VALUE_CAPTURE_EN
- Defined: each bank also stores the PIXEL_WIDTH pixel value per entry. Adds output valueOut (PIXEL_WIDTH), aligned with indexOut under the same handshake.
- Undefined: no value storage and no valueOut port. All other behaviour is identical.

Decomposition:
- Shared package/include: TRUE/FALSE, default INPUT_LAYER_NODES (784), default QUEUE_MAX_SIZE, a clog2 helper for IDX_W/CNT_W.
- Sub-module siq_bank: one storage bank with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). Data width is IDX_W, plus PIXEL_WIDTH when the feature is enabled. Instantiated twice.
- Top level holds the pointers, bank select, flags and handshake.

Test Plan:
- Reset defaults: assert reset 2 cycles with pixelValid=1 -> finished=0, overflow=0, indexValid=0, queueEmpty=1, writeCount=0, readRemaining=0.
- Basic frame: INPUT_NODES=16, QUEUE_DEPTH=8, PIXEL_WIDTH=8, threshold=128; pixels 200 at indices 2, 5, 15, others 0 -> finished after 16th beat, writeCount=3. Swap, then indexReady=1 -> indexOut 2, 5, 15 on consecutive cycles, then queueEmpty=1.
- Overflow: all 16 pixels=255 -> indices 0..7 stored, overflow=1, writeCount=8; after swap reads 0..7. Next frame starts with overflow=0.
- Early swap: swapBuffer at beat 10 -> swapRejected high 1 cycle, counter continues, read side unchanged.
- Ping-pong with backpressure: read frame A (3 entries) with indexReady toggling 1/0 while frame B scans with gaps in pixelValid -> indexOut stable during stalls, no loss. Swap after A drains -> B's entries read.
- Reset mid-operation: reset at beat 7 of a scan with 2 unread entries -> all counters clear, indexValid=0. Next full frame behaves as the basic-frame case.

Source files
------------

// File: rtl/sparse_index_queue_pkg.sv
// Shared definitions for the sparse index queue.
// Provides boolean constants, default frame/queue sizes and a clog2 helper
// used to derive index and count widths.
package sparse_index_queue_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    localparam int INPUT_LAYER_NODES = 784;
    localparam int QUEUE_MAX_SIZE    = 784;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sparse_index_queue_bank.sv
// siq_bank: one storage bank of the sparse index queue.
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable
//   waddr  - write address (entry number)
//   wdata  - write data
//   raddr  - asynchronous read address
//   rdata  - asynchronous read data (zero when raddr is past the last entry)
// Contents are never reset.
module siq_bank
    import sparse_index_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int MEM_AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // The read pointer legitimately reaches DEPTH when a bank is drained,
    // so both ports are range-guarded rather than relying on wrap.
    always_ff @(posedge clk) begin
        if (we && (waddr < ADDR_W'(DEPTH)))
            mem[waddr[MEM_AW-1:0]] <= wdata;
    end

    always_comb begin
        rdata = '0;
        if (raddr < ADDR_W'(DEPTH))
            rdata = mem[raddr[MEM_AW-1:0]];
    end

endmodule

// File: rtl/sparse_index_queue.sv
// sparse_index_queue: scans a frame of INPUT_NODES pixels and queues the index
// of every pixel >= pixelThreshold. Two banks ping-pong: one fills from the
// pixel stream while the other drains through a valid/ready handshake.
// Optional macro SIQ_VALUE_CAPTURE_EN: also stores each pixel value and
// presents it on valueOut alongside indexOut.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   pixelValid/pixelValue    - input pixel stream
//   pixelThreshold           - unsigned enqueue threshold
//   swapBuffer               - hand the filled write bank to the read side
//   finished                 - write bank has consumed a full frame
//   overflow                 - sticky, a qualifying pixel was dropped
//   writeCount               - entries in the write bank
//   swapRejected             - pulse, swap requested before frame finished
//   indexOut/indexValid      - head of read bank (valueOut when enabled)
//   indexReady               - consumer accepts head
//   queueEmpty               - ~indexValid
//   readRemaining            - unread entries in the read bank
module sparse_index_queue
    import sparse_index_queue_pkg::*;
#(
    parameter int INPUT_NODES = INPUT_LAYER_NODES,
    parameter int QUEUE_DEPTH = QUEUE_MAX_SIZE,
    parameter int PIXEL_WIDTH = 1,
    parameter int IDX_W       = clog2(INPUT_NODES),
    parameter int CNT_W       = clog2(QUEUE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixelValid,
    input  logic [PIXEL_WIDTH-1:0] pixelValue,
    input  logic [PIXEL_WIDTH-1:0] pixelThreshold,
    input  logic                   swapBuffer,
    output logic                   finished,
    output logic                   overflow,
    output logic [CNT_W-1:0]       writeCount,
    output logic                   swapRejected,
    output logic [IDX_W-1:0]       indexOut,
`ifdef SIQ_VALUE_CAPTURE_EN
    output logic [PIXEL_WIDTH-1:0] valueOut,
`endif
    output logic                   indexValid,
    input  logic                   indexReady,
    output logic                   queueEmpty,
    output logic [CNT_W-1:0]       readRemaining
);

`ifdef SIQ_VALUE_CAPTURE_EN
    localparam int DATA_W = IDX_W + PIXEL_WIDTH;
`else
    localparam int DATA_W = IDX_W;
`endif

    logic [IDX_W-1:0] pixCount;
    logic [CNT_W-1:0] wrPtr;
    logic [CNT_W-1:0] readPtr;
    logic [CNT_W-1:0] readEnd;
    logic             readSel;   // bank being drained; the other one fills

    logic             accept;
    logic             qualify;
    logic             bankFull;
    logic             lastBeat;
    logic             doWrite;
    logic             doSwap;
    logic             transfer;
    logic [DATA_W-1:0] wdata;
    logic [1:0]              bankWe;
    logic [1:0][DATA_W-1:0]  bankRdata;
    logic [DATA_W-1:0]       headData;

    assign accept   = pixelValid && !finished;
    assign qualify  = pixelValue >= pixelThreshold;
    assign bankFull = wrPtr >= CNT_W'(QUEUE_DEPTH);
    assign lastBeat = pixCount == IDX_W'(INPUT_NODES - 1);
    assign doWrite  = accept && qualify && !bankFull;
    assign doSwap   = swapBuffer && finished;
    assign transfer = indexValid && indexReady;

`ifdef SIQ_VALUE_CAPTURE_EN
    assign wdata = {pixelValue, pixCount};
`else
    assign wdata = pixCount;
`endif

    assign bankWe[0] = doWrite && readSel;
    assign bankWe[1] = doWrite && !readSel;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : gBank
            siq_bank #(
                .DEPTH  (QUEUE_DEPTH),
                .DATA_W (DATA_W),
                .ADDR_W (CNT_W)
            ) uBank (
                .clk   (clk),
                .we    (bankWe[b]),
                .waddr (wrPtr),
                .wdata (wdata),
                .raddr (readPtr),
                .rdata (bankRdata[b])
            );
        end
    endgenerate

    assign headData      = bankRdata[readSel];
    assign indexOut      = headData[IDX_W-1:0];
`ifdef SIQ_VALUE_CAPTURE_EN
    assign valueOut      = headData[DATA_W-1:IDX_W];
`endif
    assign indexValid    = readPtr != readEnd;
    assign queueEmpty    = !indexValid;
    assign writeCount    = wrPtr;
    assign readRemaining = readEnd - readPtr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pixCount     <= '0;
            wrPtr        <= '0;
            finished     <= 1'b0;
            overflow     <= 1'b0;
            swapRejected <= 1'b0;
            readSel      <= 1'b0;
            readPtr      <= '0;
            readEnd      <= '0;
        end else begin
            swapRejected <= swapBuffer && !finished;
            if (doSwap) begin
                // Swap restarts the read side, so a same-cycle transfer is
                // simply superseded by readPtr <= 0.
                readSel  <= !readSel;
                readEnd  <= wrPtr;
                readPtr  <= '0;
                pixCount <= '0;
                wrPtr    <= '0;
                finished <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (transfer)
                    readPtr <= readPtr + 1'b1;
                if (accept) begin
                    if (qualify && bankFull)
                        overflow <= 1'b1;
                    if (doWrite)
                        wrPtr <= wrPtr + 1'b1;
                    // Counter parks on the last index instead of wrapping.
                    if (lastBeat)
                        finished <= 1'b1;
                    else
                        pixCount <= pixCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_index_queue.sv
module tb_sparse_index_queue;

    localparam int N   = 16;
    localparam int D   = 8;
    localparam int PW  = 8;
    localparam int IW  = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          pixelValid;
    logic [PW-1:0] pixelValue;
    logic [PW-1:0] pixelThreshold;
    logic          swapBuffer;
    logic          finished;
    logic          overflow;
    logic [CW-1:0] writeCount;
    logic          swapRejected;
    logic [IW-1:0] indexOut;
    logic          indexValid;
    logic          indexReady;
    logic          queueEmpty;
    logic [CW-1:0] readRemaining;

    int nChecks = 0;
    int nFails  = 0;
    logic [PW-1:0] pix [N];

    sparse_index_queue #(
        .INPUT_NODES (N),
        .QUEUE_DEPTH (D),
        .PIXEL_WIDTH (PW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pixelValid     (pixelValid),
        .pixelValue     (pixelValue),
        .pixelThreshold (pixelThreshold),
        .swapBuffer     (swapBuffer),
        .finished       (finished),
        .overflow       (overflow),
        .writeCount     (writeCount),
        .swapRejected   (swapRejected),
        .indexOut       (indexOut),
        .indexValid     (indexValid),
        .indexReady     (indexReady),
        .queueEmpty     (queueEmpty),
        .readRemaining  (readRemaining)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setPix(input logic [PW-1:0] fill);
        for (int i = 0; i < N; i++) pix[i] = fill;
    endtask

    // Feed beats lo..hi back to back, then drop pixelValid.
    task automatic feed(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pixelValid = 1'b1;
            pixelValue = pix[i];
            step();
        end
        pixelValid = 1'b0;
        pixelValue = '0;
    endtask

    task automatic doSwap(input logic rdy);
        swapBuffer = 1'b1;
        indexReady = rdy;
        step();
        swapBuffer = 1'b0;
        indexReady = 1'b0;
    endtask

    task automatic basicFrame(input string tag);
        setPix(8'd0);
        pix[2] = 8'd200; pix[5] = 8'd200; pix[15] = 8'd200;
        feed(0, 14);
        chk({tag, "_notFinished15"}, finished, 0);
        feed(15, 15);
        chk({tag, "_finished"}, finished, 1);
        chk({tag, "_writeCount"}, writeCount, 3);
        chk({tag, "_overflow"}, overflow, 0);
        doSwap(1'b0);
        chk({tag, "_readRem"}, readRemaining, 3);
        chk({tag, "_head0"}, indexOut, 2);
        chk({tag, "_finClr"}, finished, 0);
        chk({tag, "_wcClr"}, writeCount, 0);
    endtask

    initial begin
        int rp;
        int bc;
        logic [IW-1:0] frameA [3];

        reset = 1'b1; pixelValid = 1'b1; pixelValue = 8'd255;
        pixelThreshold = 8'd128; swapBuffer = 1'b0; indexReady = 1'b0;
        step(); step();
        reset = 1'b0; pixelValid = 1'b0; pixelValue = '0;
        chk("rst_finished", finished, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_indexValid", indexValid, 0);
        chk("rst_queueEmpty", queueEmpty, 1);
        chk("rst_writeCount", writeCount, 0);
        chk("rst_readRemaining", readRemaining, 0);
        chk("rst_swapRejected", swapRejected, 0);

        // Basic frame, full drain one per cycle.
        basicFrame("basic");
        indexReady = 1'b1;
        step();
        chk("basic_head1", indexOut, 5);
        step();
        chk("basic_head2", indexOut, 15);
        chk("basic_valid2", indexValid, 1);
        step();
        indexReady = 1'b0;
        chk("basic_empty", queueEmpty, 1);
        chk("basic_readRem0", readRemaining, 0);

        // Overflow: every pixel qualifies, only 8 stored.
        setPix(8'd255);
        feed(0, 15);
        chk("ovf_overflow", overflow, 1);
        chk("ovf_writeCount", writeCount, 8);
        chk("ovf_finished", finished, 1);
        doSwap(1'b0);
        chk("ovf_clearOnSwap", overflow, 0);
        chk("ovf_readRem", readRemaining, 8);
        indexReady = 1'b1;
        for (int i = 0; i < D; i++) begin
            chk("ovf_head", indexOut, i);
            step();
        end
        indexReady = 1'b0;
        chk("ovf_empty", queueEmpty, 1);

        // Early swap at beat 10 (frame A: 3, 9, 12).
        setPix(8'd0);
        pix[3] = 8'd200; pix[9] = 8'd200; pix[12] = 8'd200;
        feed(0, 9);
        pixelValid = 1'b1; pixelValue = pix[10]; swapBuffer = 1'b1;
        step();
        swapBuffer = 1'b0;
        chk("early_swapRejected", swapRejected, 1);
        chk("early_finished", finished, 0);
        chk("early_writeCount", writeCount, 2);
        chk("early_readSideEmpty", queueEmpty, 1);
        chk("early_readRem", readRemaining, 0);
        feed(11, 11);
        chk("early_pulseEnds", swapRejected, 0);
        feed(12, 14);
        chk("early_notFinished", finished, 0);
        feed(15, 15);
        chk("early_finished16", finished, 1);
        chk("early_writeCount3", writeCount, 3);
        doSwap(1'b0);
        chk("early_readRemA", readRemaining, 3);

        // Ping-pong: drain A with toggling ready while B scans with gaps.
        // B qualifying: 0, 7, 8 (130 >= 128), 14; index 9 is 127.
        frameA[0] = 4'd3; frameA[1] = 4'd9; frameA[2] = 4'd12;
        setPix(8'd0);
        pix[0] = 8'd200; pix[7] = 8'd200; pix[8] = 8'd130;
        pix[9] = 8'd127; pix[14] = 8'd200;
        rp = 0; bc = 0;
        for (int c = 0; c < 60 && (bc < N || rp < 3); c++) begin
            if (rp < 3) chk("pp_head", indexOut, frameA[rp]);
            else        chk("pp_empty", queueEmpty, 1);
            pixelValid = (bc < N) && (c % 3 != 2);
            pixelValue = (bc < N) ? pix[bc] : 8'd0;
            indexReady = (c % 2 == 0);
            if (indexReady && rp < 3) rp++;
            if (pixelValid) bc++;
            step();
        end
        pixelValid = 1'b0; indexReady = 1'b0;
        chk("pp_loopBound", (bc == N && rp == 3), 1);
        chk("pp_finishedB", finished, 1);
        chk("pp_writeCountB", writeCount, 4);
        chk("pp_drainedA", queueEmpty, 1);
        doSwap(1'b0);
        chk("pp_readRemB", readRemaining, 4);
        chk("pp_B0", indexOut, 0);
        indexReady = 1'b1;
        step();
        chk("pp_B1", indexOut, 7);
        step();
        indexReady = 1'b0;
        chk("pp_B2", indexOut, 8);
        chk("pp_readRem2", readRemaining, 2);

        // Reset at beat 7 of a scan with 2 unread entries.
        setPix(8'd200);
        feed(0, 6);
        chk("mid_writeCount7", writeCount, 7);
        reset = 1'b1; pixelValid = 1'b1; pixelValue = 8'd200;
        step();
        reset = 1'b0; pixelValid = 1'b0;
        chk("mid_writeCount", writeCount, 0);
        chk("mid_finished", finished, 0);
        chk("mid_indexValid", indexValid, 0);
        chk("mid_readRem", readRemaining, 0);
        chk("mid_overflow", overflow, 0);

        basicFrame("post");
        indexReady = 1'b1;
        step();
        indexReady = 1'b0;
        chk("post_head1", indexOut, 5);
        chk("post_readRem", readRemaining, 2);

        // Zero-entry frame; swap coincides with a transfer.
        setPix(8'd0);
        feed(0, 15);
        chk("zero_finished", finished, 1);
        chk("zero_writeCount", writeCount, 0);
        doSwap(1'b1);
        chk("zero_readRem", readRemaining, 0);
        chk("zero_empty", queueEmpty, 1);
        chk("zero_indexValid", indexValid, 0);
        chk("zero_finClr", finished, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
